// File: rtl/id_stage_ctrl_pkg.sv
// Shared RV32 decode constants (opcode field codes, format classes) and ID-stage FSM types.
package id_stage_ctrl_pkg;

  // inst[6:2] opcode field codes
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // id_fmt encodings
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } id_state_e;

  function automatic logic [2:0] decode_fmt(input logic [4:0] opc);
    logic [2:0] fmt;
    case (opc)
      OPC_OP:                       fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                    fmt = FMT_S;
      OPC_BRANCH:                   fmt = FMT_B;
      OPC_AUIPC, OPC_LUI:           fmt = FMT_U;
      OPC_JAL:                      fmt = FMT_J;
      default:                      fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

  function automatic logic uses_rs1(input logic [2:0] fmt);
    return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  endfunction

  function automatic logic uses_rs2(input logic [2:0] fmt);
    return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  endfunction

endpackage

// File: rtl/id_stage_ctrl_hazard_detect.sv
// Load-use hazard: the occupied ID instruction reads a register that the load in EX has not yet written.
module hazard_detect
  import id_stage_ctrl_pkg::*;
(
  input  logic       full,
  input  logic [2:0] fmt,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = uses_rs1(fmt) && (rs1 == ex_rd);
    rs2_hit = uses_rs2(fmt) && (rs2 == ex_rd);
    // x0 is never a real dependency
    hazard  = full && ex_valid && ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage control: holds one instruction, stalls on load-use, squashes on branch, counts bubbles.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  input  logic             ex_ready,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  output logic             id_issue,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [2:0]       id_fmt,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: IF->ID transfers when if_valid && if_ready on a rising edge;
  // ID->EX transfers when id_issue (which already includes ex_ready) is high.

  id_state_e        state_q, state_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             hazard;
  logic             load;

  assign id_fmt = decode_fmt(id_inst_q[6:2]);

  hazard_detect u_hazard_detect (
    .full       (full),
    .fmt        (id_fmt),
    .rs1        (id_inst_q[19:15]),
    .rs2        (id_inst_q[24:20]),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .hazard     (hazard)
  );

  always_comb begin
    full      = (state_q != ST_EMPTY);
    id_issue  = full && !hazard && ex_ready && !branch_taken;
    if_ready  = !branch_taken && (!full || id_issue);
    load      = if_valid && if_ready;
    state_d   = state_q;
    id_inst_d = id_inst_q;
    id_pc_d   = id_pc_q;
    cnt_d     = cnt_q;

    if (branch_taken) begin
      // Squash: the held instruction is younger than the redirecting branch
      state_d   = ST_EMPTY;
      id_inst_d = NOP_INST;
      id_pc_d   = 32'd0;
    end else begin
      case (state_q)
        ST_EMPTY: if (load) state_d = ST_FULL;
        ST_FULL, ST_STALL: begin
          if (id_issue) state_d = load ? ST_FULL : ST_EMPTY;
          else          state_d = ST_STALL;
        end
        default:  state_d = ST_EMPTY;
      endcase
      if (load) begin
        id_inst_d = if_inst;
        id_pc_d   = if_pc;
      end
    end

    if (hazard && !branch_taken && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      id_inst_q <= NOP_INST;
      id_pc_q   <= 32'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_inst_q <= id_inst_d;
      id_pc_q   <= id_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/id_stage_ctrl.md
ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port if_valid  input  1  fetch stage offers an instruction.
REQ-005 SHALL have port if_inst  input  32  offered instruction word.
REQ-006 SHALL have port if_pc  input  32  PC of offered instruction.
REQ-007 SHALL have port if_ready  output  1  ID register accepts this cycle; PC held when low.
REQ-008 SHALL have port ex_ready  input  1  execute stage accepts an issued instruction.
REQ-009 SHALL have port ex_valid  input  1  execute stage holds a live instruction.
REQ-010 SHALL have port ex_is_load  input  1  EX instruction is a load.
REQ-011 SHALL have port ex_rd  input  5  EX destination register.
REQ-012 SHALL have port branch_taken  input  1  EX redirect; squash younger instructions.
REQ-013 SHALL have port id_issue  output  1  ID instruction issued to EX this cycle.
REQ-014 SHALL have port id_inst  output  32  registered instruction word.
REQ-015 SHALL have port id_pc  output  32  registered PC.
REQ-016 SHALL have port id_fmt  output  3  format class: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-017 SHALL have port stall_cnt  output  CNT_W  count of load-use bubble cycles.

Function
REQ-018 SHALL classify inst[6:2] (of id_inst): 01100 R; 00100/00000/11001 I; 01000 S; 11000 B; 00101/01101 U; 11011 J; any other 7; R and illegal both report 0 and 7 respectively.
REQ-019 SHALL treat rs1 (inst[19:15]) as used for R,I,S,B and rs2 (inst[24:20]) as used for R,S,B only.
REQ-020 SHALL raise hazard = full & ex_valid & ex_is_load & ex_rd!=0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
REQ-021 SHALL run FSM states EMPTY, FULL, STALL; reset state EMPTY.
REQ-022 SHALL drive id_issue = (state!=EMPTY) & ~hazard & ex_ready & ~branch_taken, combinationally, zero added latency.
REQ-023 SHALL drive if_ready = ~branch_taken & (state==EMPTY | id_issue).
REQ-024 SHALL load id_inst/id_pc from if_inst/if_pc on if_valid & if_ready; one-cycle IF-to-ID latency.
REQ-025 SHALL transition EMPTY->FULL on load; FULL/STALL->FULL on issue with load; ->EMPTY on issue without load.
REQ-026 SHALL transition FULL->STALL when occupied and not issued (hazard or ex_ready low); STALL holds id_inst/id_pc unchanged.
REQ-027 SHALL, on branch_taken, go to EMPTY next cycle from any state, discard ID contents and refuse if_inst; branch_taken overrides hazard and ex_ready.
REQ-028 SHALL increment stall_cnt each cycle hazard is 1 and branch_taken is 0, saturating at all-ones without wrap.
REQ-029 SHALL not issue an instruction twice: each ID load yields at most one id_issue pulse.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-stall, immediately force state EMPTY, id_inst=0x00000013 (NOP), id_pc=0, stall_cnt=0; if_ready=1, id_issue=0 while reset held.
REQ-031 SHALL release reset cleanly: first rising edge with rst_n high may load an instruction.

Structure
REQ-032 SHALL take opcode field codes and id_fmt encodings from the shared rv32_define header; no local literals.
REQ-033 SHALL place hazard comparison in one sub-module hazard_detect; FSM, registers and counter in the top.

Verification
REQ-034 SHALL test: ID=0x00728333 (add x6,x5,x7), ex_valid=1, ex_is_load=1, ex_rd=5, ex_ready=1 -> id_issue=0, if_ready=0 one cycle, stall_cnt 0->1; next cycle ex_valid=0 -> id_issue=1.
REQ-035 SHALL test: ID=0x000052B7 (lui x5), load in EX with ex_rd=5 -> no hazard, id_issue=1, id_fmt=4, stall_cnt unchanged.
REQ-036 SHALL test: ex_rd=0 load with ID rs1=0 -> no hazard, id_issue=1.
REQ-037 SHALL test: hazard and branch_taken same cycle -> id_issue=0, if_ready=0, state EMPTY next cycle, stall_cnt unchanged.
REQ-038 SHALL test: CNT_W=4, 20 consecutive hazard cycles -> stall_cnt stops at 15.
REQ-039 SHALL test: rst_n pulsed low mid-STALL -> outputs at reset values immediately, before next clock edge.
